// File: rtl/video_timing_gen_if.sv
// -----------------------------------------------------------------------------
// video_timing_gen_if
//   Pixel fetch bus between the raster generator and the upstream pixel source.
//   The generator issues a request with a column/row; the source returns the
//   24-bit {R,G,B} pixel a fixed number of cycles later. No back-pressure.
//
//   pix_req   generator -> source   request for the pixel at (pix_x, pix_y)
//   pix_x     generator -> source   requested column (12 bits)
//   pix_y     generator -> source   requested row (12 bits)
//   pix_data  source -> generator   {R,G,B}, valid a fixed latency after pix_req
//
//   master : the generator side.  slave : the pixel source side.
// -----------------------------------------------------------------------------
interface video_timing_gen_if;
  logic        pix_req;
  logic [11:0] pix_x;
  logic [11:0] pix_y;
  logic [23:0] pix_data;

  modport master (
    output pix_req,
    output pix_x,
    output pix_y,
    input  pix_data
  );

  modport slave (
    input  pix_req,
    input  pix_x,
    input  pix_y,
    output pix_data
  );
endinterface

// File: rtl/video_timing_gen.sv
// -----------------------------------------------------------------------------
// video_timing_gen
//   Raster timing and pixel generator for the HDMI output stage. Two 12-bit
//   counters walk the full raster; the active region is fetched from an
//   upstream source through a fixed-latency request bus, or replaced by an
//   internal test pattern. Every timing flag is delayed through a pipeline of
//   the same length as the pixel fetch so syncs, DE and pixels leave aligned.
//
// Ports
//   clk_pixel    pixel clock
//   reset        synchronous, active-high
//   pattern_sel  0 external pixels, 1 colour bars, 2 black, 3 white
//                (sampled only at raster position (0,0))
//   pix_bus      master side of the pixel fetch bus (pix_req/x/y, pix_data)
//   RED/GREEN/BLUE  pixel components, zero outside active video
//   HSYNC/VSYNC  syncs at the configured polarity
//   video_de     active video
//   frame_start  one-cycle pulse with output pixel (0,0)
//   line_start   one-cycle pulse with output pixel x=0 of each active line
//
// Counter state in cycle t appears on the outputs in cycle t+PIX_LATENCY+2.
// PIX_LATENCY must be in 1..4; horizontal and vertical totals must not
// exceed 4096.
// -----------------------------------------------------------------------------
module video_timing_gen #(
  parameter int H_ACTIVE    = 640,
  parameter int H_FP        = 16,
  parameter int H_SYNC      = 96,
  parameter int H_BP        = 48,
  parameter int V_ACTIVE    = 480,
  parameter int V_FP        = 10,
  parameter int V_SYNC      = 2,
  parameter int V_BP        = 33,
  parameter bit HS_POL      = 1'b0,
  parameter bit VS_POL      = 1'b0,
  parameter int PIX_LATENCY = 2
) (
  input  logic                      clk_pixel,
  input  logic                      reset,
  input  logic [1:0]                pattern_sel,
  video_timing_gen_if.master        pix_bus,
  output logic [7:0]                RED,
  output logic [7:0]                GREEN,
  output logic [7:0]                BLUE,
  output logic                      HSYNC,
  output logic                      VSYNC,
  output logic                      video_de,
  output logic                      frame_start,
  output logic                      line_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int BAR_W   = H_ACTIVE / 8;

  // 13-bit compare limits so a boundary equal to 4096 still compares correctly
  localparam logic [12:0] H_ACT_END = 13'(H_ACTIVE);
  localparam logic [12:0] HS_START  = 13'(H_ACTIVE + H_FP);
  localparam logic [12:0] HS_END    = 13'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [12:0] V_ACT_END = 13'(V_ACTIVE);
  localparam logic [12:0] VS_START  = 13'(V_ACTIVE + V_FP);
  localparam logic [12:0] VS_END    = 13'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [11:0] H_LAST    = 12'(H_TOTAL - 1);
  localparam logic [11:0] V_LAST    = 12'(V_TOTAL - 1);

  // Per-pixel timing bundle carried from the request stage to the output.
  typedef struct packed {
    logic        de;   // active video
    logic        hs;   // hsync asserted (polarity not yet applied)
    logic        vs;   // vsync asserted (polarity not yet applied)
    logic        fs;   // pixel (0,0)
    logic        ls;   // x=0 of an active line
    logic        ext;  // take the pixel from pix_data rather than rgb
    logic [23:0] rgb;  // internal pattern colour
  } flags_t;

  // Colour bar palette, left to right.
  function automatic logic [23:0] bar_colour(input logic [2:0] bar);
    logic [23:0] c;
    case (bar)
      3'd0:    c = 24'hFFFFFF;
      3'd1:    c = 24'hFFFF00;
      3'd2:    c = 24'h00FFFF;
      3'd3:    c = 24'h00FF00;
      3'd4:    c = 24'hFF00FF;
      3'd5:    c = 24'hFF0000;
      3'd6:    c = 24'h0000FF;
      default: c = 24'h000000;
    endcase
    return c;
  endfunction

  // Bar index by threshold compare; the last bar absorbs the remainder of
  // H_ACTIVE/8 since nothing above bar 7 exists.
  function automatic logic [23:0] pattern_rgb(input logic [1:0] mode,
                                              input logic [11:0] h);
    logic [2:0]  bar;
    logic [23:0] c;
    bar = 3'd0;
    for (int i = 1; i < 8; i++) begin
      if ({1'b0, h} >= 13'(i * BAR_W)) bar = 3'(i);
    end
    case (mode)
      2'd1:    c = bar_colour(bar);
      2'd3:    c = 24'hFFFFFF;
      default: c = 24'h000000;
    endcase
    return c;
  endfunction

  logic [11:0] h_cnt_q, h_cnt_d;
  logic [11:0] v_cnt_q, v_cnt_d;
  logic [1:0]  mode_q, mode_d;
  logic [1:0]  mode_cur;
  logic        at_origin;
  logic        active;
  logic        hs_raw;
  logic        vs_raw;

  logic        pix_req_q, pix_req_d;
  logic [11:0] pix_x_q, pix_x_d;
  logic [11:0] pix_y_q, pix_y_d;

  flags_t      flags_q [0:PIX_LATENCY];
  flags_t      flags_d [0:PIX_LATENCY];

  logic [23:0] rgb_q, rgb_d;
  logic        hsync_q, hsync_d;
  logic        vsync_q, vsync_d;
  logic        de_q, de_d;
  logic        fs_q, fs_d;
  logic        ls_q, ls_d;

  // ---- stage 0: raster counters and decode ----
  always_comb begin
    h_cnt_d = h_cnt_q + 12'd1;
    v_cnt_d = v_cnt_q;
    if (h_cnt_q == H_LAST) begin
      h_cnt_d = 12'd0;
      v_cnt_d = (v_cnt_q == V_LAST) ? 12'd0 : v_cnt_q + 12'd1;
    end

    at_origin = (h_cnt_q == 12'd0) && (v_cnt_q == 12'd0);
    // The mode is latched at the top of the frame so a change never tears;
    // pixel (0,0) already uses the newly sampled value.
    mode_cur  = at_origin ? pattern_sel : mode_q;
    mode_d    = mode_cur;

    active = ({1'b0, h_cnt_q} < H_ACT_END) && ({1'b0, v_cnt_q} < V_ACT_END);
    hs_raw = ({1'b0, h_cnt_q} >= HS_START) && ({1'b0, h_cnt_q} < HS_END);
    // v_cnt only moves on the h_cnt wrap, so vsync edges land on h_cnt = 0.
    vs_raw = ({1'b0, v_cnt_q} >= VS_START) && ({1'b0, v_cnt_q} < VS_END);
  end

  // ---- stage 0 -> request stage ----
  always_comb begin
    pix_req_d = active && (mode_cur == 2'd0);
    pix_x_d   = pix_req_d ? h_cnt_q : pix_x_q;
    pix_y_d   = pix_req_d ? v_cnt_q : pix_y_q;

    flags_d[0].de  = active;
    flags_d[0].hs  = hs_raw;
    flags_d[0].vs  = vs_raw;
    flags_d[0].fs  = at_origin;
    flags_d[0].ls  = (h_cnt_q == 12'd0) && ({1'b0, v_cnt_q} < V_ACT_END);
    flags_d[0].ext = (mode_cur == 2'd0);
    flags_d[0].rgb = pattern_rgb(mode_cur, h_cnt_q);

    // Delay line matching the upstream fetch latency.
    for (int k = 1; k <= PIX_LATENCY; k++) begin
      flags_d[k] = flags_q[k-1];
    end
  end

  // ---- data stage: pix_data aligned with flags_q[PIX_LATENCY] -> output ----
  always_comb begin
    rgb_d = 24'h000000;
    if (flags_q[PIX_LATENCY].de) begin
      rgb_d = flags_q[PIX_LATENCY].ext ? pix_bus.pix_data : flags_q[PIX_LATENCY].rgb;
    end
    hsync_d = flags_q[PIX_LATENCY].hs ? HS_POL : ~HS_POL;
    vsync_d = flags_q[PIX_LATENCY].vs ? VS_POL : ~VS_POL;
    de_d    = flags_q[PIX_LATENCY].de;
    fs_d    = flags_q[PIX_LATENCY].fs;
    ls_d    = flags_q[PIX_LATENCY].ls;
  end

  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      h_cnt_q   <= 12'd0;
      v_cnt_q   <= 12'd0;
      mode_q    <= 2'd0;
      pix_req_q <= 1'b0;
      pix_x_q   <= 12'd0;
      pix_y_q   <= 12'd0;
      for (int k = 0; k <= PIX_LATENCY; k++) begin
        flags_q[k] <= '0;
      end
      rgb_q     <= 24'h000000;
      hsync_q   <= ~HS_POL;
      vsync_q   <= ~VS_POL;
      de_q      <= 1'b0;
      fs_q      <= 1'b0;
      ls_q      <= 1'b0;
    end else begin
      h_cnt_q   <= h_cnt_d;
      v_cnt_q   <= v_cnt_d;
      mode_q    <= mode_d;
      pix_req_q <= pix_req_d;
      pix_x_q   <= pix_x_d;
      pix_y_q   <= pix_y_d;
      for (int k = 0; k <= PIX_LATENCY; k++) begin
        flags_q[k] <= flags_d[k];
      end
      rgb_q     <= rgb_d;
      hsync_q   <= hsync_d;
      vsync_q   <= vsync_d;
      de_q      <= de_d;
      fs_q      <= fs_d;
      ls_q      <= ls_d;
    end
  end

  assign pix_bus.pix_req = pix_req_q;
  assign pix_bus.pix_x   = pix_x_q;
  assign pix_bus.pix_y   = pix_y_q;

  assign RED         = rgb_q[23:16];
  assign GREEN       = rgb_q[15:8];
  assign BLUE        = rgb_q[7:0];
  assign HSYNC       = hsync_q;
  assign VSYNC       = vsync_q;
  assign video_de    = de_q;
  assign frame_start = fs_q;
  assign line_start  = ls_q;

endmodule

// File: doc/video_timing_gen.md
Name: video_timing_gen

Overview:
- Generates raster timing and pixel data for the HDMI output stage: RED/GREEN/BLUE, HSYNC, VSYNC, video_de, all in the clk_pixel domain.
- Default timing is 640x480@60 at a 25 MHz pixel clock.
- Fetches pixels from an upstream source through a fixed-latency request interface. It can also substitute internal test patterns.
- All timing outputs are delayed to align exactly with the returned pixel data.

Parameters:
- H_ACTIVE, 640, active pixels per line
- H_FP, 16, horizontal front porch (cycles)
- H_SYNC, 96, hsync width (cycles)
- H_BP, 48, horizontal back porch (cycles)
- V_ACTIVE, 480, active lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync width (lines)
- V_BP, 33, vertical back porch (lines)
- HS_POL, 0, hsync active level (0 = active-low)
- VS_POL, 0, vsync active level (0 = active-low)
- PIX_LATENCY, 2, cycles from pix_req to valid pix_data; legal range 1..4

Ports:
- clk_pixel  in  1  pixel clock
- reset  in  1  synchronous, active-high reset
- pattern_sel  in  2  0 = external pixels, 1 = colour bars, 2 = black, 3 = white
- pix_req  out  1  pixel request; high for active pixels in mode 0 only
- pix_x  out  12  requested column
- pix_y  out  12  requested row
- pix_data  in  24  {R,G,B}; valid PIX_LATENCY cycles after pix_req
- RED  out  8  red to HDMI_out
- GREEN  out  8  green to HDMI_out
- BLUE  out  8  blue to HDMI_out
- HSYNC  out  1  horizontal sync
- VSYNC  out  1  vertical sync
- video_de  out  1  active video
- frame_start  out  1  one-cycle pulse with output pixel (0,0)
- line_start  out  1  one-cycle pulse with output pixel x=0 of each active line

Behaviour:
- Counters:
  - h_cnt runs 0..H_TOTAL-1, where H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP.
  - v_cnt increments when h_cnt wraps and runs 0..V_TOTAL-1, where V_TOTAL is defined the same way from the V_ parameters.
  - Both counters are 12 bits. Totals must not exceed 4096.
- Stage-0 decode from the counters:
  - active = h_cnt < H_ACTIVE and v_cnt < V_ACTIVE.
  - hs_raw is asserted for H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC.
  - vs_raw is asserted for V_ACTIVE+V_FP <= v_cnt < V_ACTIVE+V_FP+V_SYNC, over whole lines, and changes only where h_cnt = 0.
- Request stage (registered):
  - If counters are (h,v) in cycle t, then in cycle t+1: pix_req = active and mode 0; pix_x = h; pix_y = v.
  - When pix_req = 0, pix_x and pix_y hold their last values.
- Data stage:
  - pix_data is sampled in cycle t+1+PIX_LATENCY.
  - RED, GREEN, BLUE, HSYNC, VSYNC, video_de, frame_start and line_start are registered and appear in cycle t+2+PIX_LATENCY.
  - Total counter-to-output latency is PIX_LATENCY+2.
  - All timing flags travel through an equal-length shift register.
- Output pixel value:
  - When video_de = 0, RGB = 0 in every mode.
  - In mode 0, RGB = pix_data.
  - Mode 1 is 8 vertical bars, each H_ACTIVE/8 wide (integer division); the final bar absorbs any remainder. Colour order is white, yellow, cyan, green, magenta, red, blue, black, using component values FF/00.
  - Pattern colours are computed at the request stage and delayed through the same pipeline, so alignment is identical to mode 0.
- pattern_sel is captured only while the counters are at (0,0). A mid-frame change takes effect from the next frame, with no tearing.
- Output sync levels: HSYNC = hs ? HS_POL : ~HS_POL; VSYNC follows the same rule with VS_POL.
- Reset:
  - Counters go to (0,0) and all pipeline registers clear.
  - pix_req = 0; pix_x = pix_y = 0.
  - RGB = 0; video_de = 0; frame_start = line_start = 0.
  - HSYNC = ~HS_POL and VSYNC = ~VS_POL (inactive levels).
  - Captured mode = 0.
  - Reset asserted mid-frame takes effect on the next edge.
- After reset release: the counters are at (0,0) in the first cycle with reset low, and the first video_de follows PIX_LATENCY+2 cycles later. No partial frame is emitted.
- Wrap conditions:
  - At h_cnt = H_TOTAL-1, h_cnt returns to 0 and v_cnt advances.
  - When h_cnt and v_cnt are both at their last values, both return to 0.

Test Plan:
- Default parameters, mode 1, run 2 frames:
  - video_de period is 800 cycles with 640 high.
  - HSYNC goes low 16 cycles after video_de falls and stays low 96 cycles.
  - VSYNC is low for 1600 cycles starting at line 490.
  - Frame period is 420000 cycles; exactly 480 line_start pulses and 1 frame_start pulse per frame.
- Latency, mode 0, PIX_LATENCY in {1,2,4}:
  - Bench model returns pix_data = {x[7:0], y[7:0], 8'hA5} delayed by PIX_LATENCY.
  - Every cycle with video_de = 1 shows RED = column, GREEN = row, BLUE = A5.
  - Zero misaligned pixels at the line edges.
- Colour bars, mode 1: the output pixel at x=0 is FFFFFF, x=80 is FFFF00, x=560 is 000000, and blanking is 000000.
- Mode switch: change pattern_sel from 1 to 3 at line 100. Bars continue to the end of that frame; the next frame is all FFFFFF; pix_req stays 0 throughout.
- Reset mid-frame at line 237, held 3 cycles:
  - All outputs hold reset values during reset.
  - video_de rises exactly 4 cycles after release (PIX_LATENCY = 2), together with frame_start.
- Small parameters (H 8/2/2/2, V 4/1/1/1) with HS_POL = VS_POL = 1:
  - Sync pulses are active-high.
  - Frame period is 14*7 = 98 cycles.
